uint_addsub_pipe: RTL

UINT_ADDSUB_PIPE -- requirements
Module: uint_addsub_pipe

---
 rtl/uint_addsub_pipe.sv | 90 +++++++++
 1 files changed

// File: rtl/uint_addsub_pipe.sv
// Registered unsigned SUB/ADD/ACC_SUB/LOAD with optional saturation; 1-cycle latency.
// Single output register with valid/ready; input stalls only while a result is held unconsumed.
module uint_addsub_pipe #(
    parameter int WIDTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [1:0]       OP,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] O,
    output logic             C,
    output logic             O_VALID,
    input  logic             O_READY
);

    localparam logic [1:0] OP_SUB     = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b01;
    localparam logic [1:0] OP_ACC_SUB = 2'b10;
    localparam logic [1:0] OP_LOAD    = 2'b11;

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] res;
    logic             flag;
    logic             take;

    assign IN_READY = !O_VALID || O_READY;
    assign take     = IN_VALID && IN_READY;

    // One extra bit holds the carry out, or the borrow of a zero-extended subtract.
    always_comb begin
        ext  = '0;
        res  = I0;
        flag = 1'b0;
        case (OP)
            OP_SUB: begin
                ext  = {1'b0, I0} - {1'b0, I1};
                res  = ext[WIDTH-1:0];
                flag = ext[WIDTH];
            end
            OP_ADD: begin
                ext  = {1'b0, I0} + {1'b0, I1};
                res  = ext[WIDTH-1:0];
                flag = ext[WIDTH];
            end
            OP_ACC_SUB: begin
                ext  = {1'b0, acc} - {1'b0, I1};
                res  = ext[WIDTH-1:0];
                flag = ext[WIDTH];
            end
            OP_LOAD: begin
                res  = I0;
                flag = 1'b0;
            end
            default: begin
                res  = I0;
                flag = 1'b0;
            end
        endcase
        if (SATURATE && flag) begin
            res = (OP == OP_ADD) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            O       <= '0;
            C       <= 1'b0;
            O_VALID <= 1'b0;
            acc     <= '0;
        end else begin
            if (take) begin
                O       <= res;
                C       <= flag;
                O_VALID <= 1'b1;
                // ACC_SUB and LOAD both leave the final result in the accumulator.
                if (OP[1]) begin
                    acc <= res;
                end
            end else if (O_READY) begin
                O_VALID <= 1'b0;
            end
        end
    end

endmodule
